risc_controller_mc: RTL and testbench



---
 rtl/risc_controller_mc.sv | 143 ++++++++++++++
 tb/tb_risc_controller_mc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_controller_mc.sv
// risc_controller_mc: multi-cycle VeriRISC control FSM with memory wait states, halt modes and timeout fault.
// Defining RISC_CTRL_PERF_CNT_EN adds saturating instr_cnt/stall_cnt counters.
module risc_controller_mc #(
  parameter int HLT_MODE   = 0,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             run,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    FAULT      = 4'd9
  } state_t;
  typedef enum logic [2:0] {
    OPC_HLT, OPC_SKZ, OPC_ADD, OPC_AND, OPC_XOR, OPC_LDA, OPC_STO, OPC_JMP
  } opcode_t;
  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WW-1:0] LIM_M1 = WW'(WAIT_LIMIT - 1);
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  opcode_t       op;
  logic          aluop, stall, timeout;
  assign op      = opcode_t'(opcode);
  assign aluop   = op inside {OPC_ADD, OPC_AND, OPC_XOR, OPC_LDA};
  assign stall   = !mem_ready && (state_q == INST_FETCH || (state_q == OP_FETCH && aluop) ||
                                  (state_q == STORE && op == OPC_STO));
  // the stall that would push the count to WAIT_LIMIT faults instead
  assign timeout = stall && (WAIT_LIMIT != 0) && (wait_q == LIM_M1);
  assign wait_d  = stall ? wait_q + WW'(1) : '0;
  assign state   = state_q;
  assign instr_done = (state_q == STORE) && !stall;
  always_comb begin
    state_d = INST_ADDR;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (HLT_MODE == 1 && op == OPC_HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     state_d = run ? INST_ADDR : HALTED;
      FAULT:      state_d = FAULT;
      default:    state_d = INST_ADDR;
    endcase
    if (stall) state_d = timeout ? FAULT : state_q;
  end
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    fault   = 1'b0;
    case (state_q)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = op == OPC_HLT;
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == OPC_SKZ) && zero;
        load_pc = op == OPC_JMP;
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = op == OPC_JMP;
        load_pc = op == OPC_JMP;
        mem_wr  = op == OPC_STO;
      end
      HALTED: halt = 1'b1;
      FAULT: begin
        halt  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INST_ADDR;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
`ifdef RISC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;
  assign instr_cnt_d = (instr_done && !(&instr_cnt_q)) ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_risc_controller_mc.sv
// tb_risc_controller_mc: legacy-halt and sticky-halt instances driven in lockstep, checked against a phase-trace model.
module tb_risc_controller_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  opcode = 3'd0;
  logic        zero = 1'b0, mem_ready = 1'b0, run = 1'b0;
  logic        mem_rd [2], load_ir [2], halt [2], inc_pc [2], load_ac [2], load_pc [2], mem_wr [2];
  logic [3:0]  state [2];
  logic        instr_done [2], fault [2];
  logic [15:0] icnt [2], scnt [2];
  int          n_cmp = 0, n_bad = 0;
  int          e_icnt = 0, e_scnt = 0;
  typedef struct {int p; logic r;} ent_t;

  always #5 clk = ~clk;

  risc_controller_mc #(.HLT_MODE(0), .WAIT_LIMIT(15), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .run(run),
    .mem_rd(mem_rd[0]), .load_ir(load_ir[0]), .halt(halt[0]), .inc_pc(inc_pc[0]),
    .load_ac(load_ac[0]), .load_pc(load_pc[0]), .mem_wr(mem_wr[0]), .state(state[0]),
    .instr_done(instr_done[0]), .fault(fault[0]), .instr_cnt(icnt[0]), .stall_cnt(scnt[0]));
  risc_controller_mc #(.HLT_MODE(1), .WAIT_LIMIT(15), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .run(run),
    .mem_rd(mem_rd[1]), .load_ir(load_ir[1]), .halt(halt[1]), .inc_pc(inc_pc[1]),
    .load_ac(load_ac[1]), .load_pc(load_pc[1]), .mem_wr(mem_wr[1]), .state(state[1]),
    .instr_done(instr_done[1]), .fault(fault[1]), .instr_cnt(icnt[1]), .stall_cnt(scnt[1]));

  function automatic logic [6:0] strb(input int k);
    return {mem_rd[k], load_ir[k], halt[k], inc_pc[k], load_ac[k], load_pc[k], mem_wr[k]};
  endfunction

  // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} for a phase of the instruction cycle
  function automatic logic [6:0] exp_str(input int p, input logic [2:0] op, input logic z);
    logic alu, sk, jm, st;
    alu = (op >= 3'd2) && (op <= 3'd5);
    sk  = op == 3'd1;
    jm  = op == 3'd7;
    st  = op == 3'd6;
    case (p)
      1:       return 7'b1000000;
      2, 3:    return 7'b1100000;
      4:       return {2'b00, op == 3'd0, 1'b1, 3'b000};
      5:       return {alu, 6'b0};
      6:       return {alu, 2'b00, sk & z, alu, jm, 1'b0};
      7:       return {alu, 2'b00, jm, alu, jm, st};
      8, 9:    return 7'b0010000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int ce(input int v);
`ifdef RISC_CTRL_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input int p0, input logic d0, input int p1, input logic d1,
                      input int mask);
    mem_ready = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (mask[k]) begin
        int   p;
        logic d;
        p = (k == 1) ? p1 : p0;
        d = (k == 1) ? d1 : d0;
        chk($sformatf("state[%0d] p=%0d", k, p), 32'(state[k]), p);
        chk($sformatf("strobes[%0d] p=%0d op=%0d", k, p, opcode), 32'(strb(k)), 32'(exp_str(p, opcode, zero)));
        chk($sformatf("instr_done[%0d] p=%0d", k, p), 32'(instr_done[k]), 32'(d));
        chk($sformatf("fault[%0d] p=%0d", k, p), 32'(fault[k]), 32'(p == 9));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s instr_cnt[%0d]", tag, k), 32'(icnt[k]), ce(e_icnt));
      chk($sformatf("%s stall_cnt[%0d]", tag, k), 32'(scnt[k]), ce(e_scnt));
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s state[%0d]", tag, k), 32'(state[k]), 0);
        chk($sformatf("%s strobes[%0d]", tag, k), 32'(strb(k)), 0);
        chk($sformatf("%s fault[%0d]", tag, k), 32'(fault[k]), 0);
        chk($sformatf("%s done[%0d]", tag, k), 32'(instr_done[k]), 0);
        chk($sformatf("%s icnt[%0d]", tag, k), 32'(icnt[k]), 0);
        chk($sformatf("%s scnt[%0d]", tag, k), 32'(scnt[k]), 0);
      end
    end
    rst = 1'b0;
    e_icnt = 0;
    e_scnt = 0;
  endtask

  // one full instruction with s1/s5/s7 not-ready cycles at the three memory wait points
  task automatic run_instr(input logic [2:0] op, input logic z, input int s1, input int s5, input int s7);
    ent_t q[$];
    logic alu;
    alu = (op >= 3'd2) && (op <= 3'd5);
    opcode = op;
    zero = z;
    q.push_back('{0, 1'($urandom)});
    repeat (s1) q.push_back('{1, 1'b0});
    q.push_back('{1, 1'b1});
    for (int p = 2; p <= 4; p++) q.push_back('{p, 1'($urandom)});
    if (alu) begin
      repeat (s5) q.push_back('{5, 1'b0});
      q.push_back('{5, 1'b1});
    end else q.push_back('{5, 1'($urandom)});
    q.push_back('{6, 1'($urandom)});
    if (op == 3'd6) begin
      repeat (s7) q.push_back('{7, 1'b0});
      q.push_back('{7, 1'b1});
    end else q.push_back('{7, 1'($urandom)});
    foreach (q[i]) begin
      run = 1'($urandom);
      step(q[i].r, q[i].p, i == q.size() - 1, q[i].p, i == q.size() - 1, 3);
    end
    run = 1'b0;
    e_icnt++;
    e_scnt += s1 + (alu ? s5 : 0) + ((op == 3'd6) ? s7 : 0);
    chk_cnt($sformatf("op%0d", op));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset("reset");
    run_instr(3'd2, 1'b0, 0, 0, 0);
    run_instr(3'd5, 1'b0, 0, 3, 0);
    run_instr(3'd1, 1'b1, 0, 0, 0);
    run_instr(3'd1, 1'b0, 0, 0, 0);
    run_instr(3'd7, 1'b1, 0, 0, 0);
    run_instr(3'd6, 1'b0, 2, 0, 5);
    run_instr(3'd5, 1'b1, 14, 14, 0);
    run_instr(3'd6, 1'b1, 14, 0, 14);
    for (int i = 0; i < 25; i++) begin
      int hi;
      hi = ($urandom_range(0, 7) == 0) ? 14 : 5;
      run_instr(3'($urandom_range(1, 7)), 1'($urandom), $urandom_range(0, hi),
                $urandom_range(0, hi), $urandom_range(0, hi));
    end
    // reset while stalled mid-STORE
    opcode = 3'd6;
    zero = 1'b0;
    for (int p = 0; p <= 6; p++) step(1'b1, p, 1'b0, p, 1'b0, 3);
    step(1'b0, 7, 1'b0, 7, 1'b0, 3);
    step(1'b0, 7, 1'b0, 7, 1'b0, 3);
    do_reset("reset_store");
    // HLT: legacy instance passes through, sticky instance parks in HALTED
    opcode = 3'd0;
    for (int p = 0; p <= 3; p++) step(1'b1, p, 1'b0, p, 1'b0, 3);
    run = 1'b1;
    step(1'b1, 4, 1'b0, 4, 1'b0, 3);
    run = 1'b0;
    step(1'b0, 5, 1'b0, 8, 1'b0, 3);
    step(1'b0, 6, 1'b0, 8, 1'b0, 3);
    step(1'b0, 7, 1'b1, 8, 1'b0, 3);
    repeat (17) step(1'($urandom), 0, 1'b0, 8, 1'b0, 2);
    run = 1'b1;
    step(1'b1, 0, 1'b0, 8, 1'b0, 2);
    run = 1'b0;
    step(1'b1, 0, 1'b0, 0, 1'b0, 2);
    do_reset("reset_halt");
    // STO never ready in STORE: fault after 15 stalled cycles
    opcode = 3'd6;
    for (int p = 0; p <= 6; p++) step(1'b1, p, 1'b0, p, 1'b0, 3);
    repeat (15) step(1'b0, 7, 1'b0, 7, 1'b0, 3);
    repeat (6) begin
      run = 1'($urandom);
      step(1'($urandom), 9, 1'b0, 9, 1'b0, 3);
    end
    run = 1'b0;
    e_scnt = 15;
    chk_cnt("fault");
    do_reset("reset_fault");
    run_instr(3'd4, 1'b0, 1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
